// File: rtl/lzd_norm_ctrl.sv
// ---------------------------------------------------------------------------
// lzd_norm_ctrl
//
// Purpose:
//   Normalizes a W-bit word (W = 8*NBYTES). The word is shifted left until
//   its most significant set bit lands in bit W-1. The leading-zero count is
//   found one byte per cycle with a single 8-bit leading-zero detector. The
//   scan starts at the MSB byte and stops at the first nonzero byte. A
//   separate cycle then applies the shift.
//
//   Latency is measured from the accepting cycle to the first out_valid
//   cycle. It is k+2 cycles, where k is the number of bytes scanned
//   (1..NBYTES).
//
// Handshake (both ports):
//   A transfer happens on a rising edge where valid && ready are both high.
//   The producer keeps valid asserted and its data stable until that edge.
//   The consumer may drive ready independently of valid.
//   out_data, out_lz and out_zero stay stable while out_valid && !out_ready.
//
// Optional feature (macro LZD_NORM_FAST_TURN_EN):
//   When this macro is defined, in_ready is also high in DONE while
//   out_ready is high. A result handshake and a new acceptance can then
//   happen on the same edge, and the FSM goes straight from DONE to SCAN.
//   When it is undefined, at least one IDLE cycle separates two words.
//
// Ports:
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous active-high reset; while it is high, every
//                   output reads 0
//   in_valid   in   upstream word valid
//   in_ready   out  block can accept a word
//   in_data    in   [W-1:0] word to normalize
//   out_valid  out  result valid (DONE only)
//   out_ready  in   downstream accepts result
//   out_data   out  [W-1:0] in_data << out_lz (0 for an all-zero word)
//   out_lz     out  [clog2(W):0] leading-zero count, 0..W
//   out_zero   out  accepted word was all zero
//   dbg_state  out  [1:0] current FSM state (IDLE=0, SCAN=1, SHIFT=2, DONE=3)
// ---------------------------------------------------------------------------
module lzd_norm_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [8*NBYTES-1:0]           in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [8*NBYTES-1:0]           out_data,
    output logic [$clog2(8*NBYTES):0]     out_lz,
    output logic                          out_zero,
    output logic [1:0]                    dbg_state
);

    localparam int W   = 8 * NBYTES;
    localparam int LZW = $clog2(W) + 1;
    localparam int IW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [IW-1:0]  IDX_MSB = IW'(NBYTES - 1);
    localparam logic [LZW-1:0] LZ_FULL = LZW'(W);
    localparam logic [LZW-1:0] LZ_BYTE = LZW'(8);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    logic [W-1:0]    word;
    logic [IW-1:0]   idx;
    logic [LZW-1:0]  cnt;
    logic [LZW-1:0]  lz;
    logic            zero;

    logic            out_valid_q;
    logic [W-1:0]    out_data_q;
    logic [LZW-1:0]  out_lz_q;
    logic            out_zero_q;

    logic [7:0]      cur_byte;
    logic [2:0]      byte_lz;
    logic            accept;

    // Leading-zero count of one byte. A zero byte returns 0; the caller
    // handles that case separately.
    function automatic logic [2:0] lzd8(input logic [7:0] b);
        logic [2:0] r;
        r = 3'd0;
        // Ascending loop: the highest set bit is the last one to write r.
        for (int j = 0; j < 8; j++) begin
            if (b[j]) r = 3'(7 - j);
        end
        return r;
    endfunction

    // Byte selected by the scan index, built as an explicit mux.
    always_comb begin
        cur_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (idx == IW'(b)) cur_byte = word[b*8 +: 8];
        end
    end

    assign byte_lz = lzd8(cur_byte);

    // in_ready is combinational. It is gated by rst, so it reads 0 for the
    // whole time rst is high, including the first cycle of reset.
`ifdef LZD_NORM_FAST_TURN_EN
    assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
`else
    assign in_ready = !rst && (state == IDLE);
`endif

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word        <= '0;
            idx         <= '0;
            cnt         <= '0;
            lz          <= '0;
            zero        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_lz_q    <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        word  <= in_data;
                        idx   <= IDX_MSB;
                        cnt   <= '0;
                        zero  <= 1'b0;
                        state <= SCAN;
                    end
                end

                SCAN: begin
                    if (cur_byte != 8'h00) begin
                        // cnt already equals 8*(NBYTES-1-idx), so adding
                        // the byte count gives the full leading-zero count.
                        lz    <= cnt + {{(LZW-3){1'b0}}, byte_lz};
                        state <= SHIFT;
                    end else if (idx == '0) begin
                        lz    <= LZ_FULL;
                        zero  <= 1'b1;
                        state <= SHIFT;
                    end else begin
                        cnt <= cnt + LZ_BYTE;
                        idx <= idx - IW'(1);
                    end
                end

                SHIFT: begin
                    // lz == W always means an all-zero word. The explicit
                    // zero keeps the meaning clear and does not depend on
                    // how an oversized shift behaves.
                    out_data_q  <= (lz >= LZ_FULL) ? '0 : (word << lz);
                    out_lz_q    <= lz;
                    out_zero_q  <= zero;
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
`ifdef LZD_NORM_FAST_TURN_EN
                        if (accept) begin
                            word  <= in_data;
                            idx   <= IDX_MSB;
                            cnt   <= '0;
                            zero  <= 1'b0;
                            state <= SCAN;
                        end
`endif
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // The registered results are masked by rst, so every output is 0
    // while reset is held, even before the first reset edge clears them.
    assign out_valid = out_valid_q && !rst;
    assign out_data  = rst ? '0 : out_data_q;
    assign out_lz    = rst ? '0 : out_lz_q;
    assign out_zero  = out_zero_q && !rst;
    assign dbg_state = state;

endmodule

// File: tb/tb_lzd_norm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lzd_norm_ctrl
//
// Self-checking bench for lzd_norm_ctrl at NBYTES=4 (W=32).
// A table of directed vectors covers the main function. Hand-written
// sequences cover reset, a stalled DONE, reset during SCAN, and
// back-to-back words.
// ---------------------------------------------------------------------------
module tb_lzd_norm_ctrl;

  localparam int W   = 32;
  localparam int LZW = 6;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [LZW-1:0] out_lz;
  logic           out_zero;
  logic [1:0]     dbg_state;

  int errors = 0;
  int checks = 0;

  lzd_norm_ctrl #(.NBYTES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lz    (out_lz),
    .out_zero  (out_zero),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0]   data;
    int             lat;
    logic [LZW-1:0] lz;
    logic [W-1:0]   res;
    logic           zero;
  } vec_t;

  vec_t vecs[9];

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Offers one word and measures latency from the accepting cycle to the
  // first out_valid cycle. It then holds out_ready low for 'hold' cycles
  // and checks the result outputs.
  task automatic run_word(input string tag, input logic [W-1:0] d, input int exp_lat,
                          input logic [LZW-1:0] exp_lz, input logic [W-1:0] exp_res,
                          input logic exp_zero, input int hold);
    int guard;
    int lat;
    @(negedge clk);
    in_data   = d;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_lz"},   {26'd0, out_lz}, {26'd0, exp_lz});
    check({tag, "_data"}, out_data, exp_res);
    check({tag, "_zero"}, {31'd0, out_zero}, {31'd0, exp_zero});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hold_lz"},    {26'd0, out_lz}, {26'd0, exp_lz});
      check({tag, "_hold_data"},  out_data, exp_res);
      check({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_released"}, {31'd0, out_valid}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n_res;
    int first_cyc;
    int gap;
    int sent;
    logic [LZW-1:0] lz_seen[2];
    logic acc;

    //            data           lat lz       result         zero
    vecs[0] = '{32'h8000_0000, 3, 6'd0,  32'h8000_0000, 1'b0};
    vecs[1] = '{32'h0080_0000, 4, 6'd8,  32'h8000_0000, 1'b0};
    vecs[2] = '{32'h0000_0001, 6, 6'd31, 32'h8000_0000, 1'b0};
    vecs[3] = '{32'h0000_0000, 6, 6'd32, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h1234_5678, 3, 6'd3,  32'h91A2_B3C0, 1'b0};
    vecs[5] = '{32'h0001_0000, 4, 6'd15, 32'h8000_0000, 1'b0};
    vecs[6] = '{32'h0000_3C00, 5, 6'd18, 32'hF000_0000, 1'b0};
    vecs[7] = '{32'h0000_00FF, 6, 6'd24, 32'hFF00_0000, 1'b0};
    vecs[8] = '{32'h4000_0000, 3, 6'd1,  32'h8000_0000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // Reset state: outputs 0, not ready while rst is high.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_data",  out_data, 32'd0);
    check("rst_lz",    {26'd0, out_lz}, 32'd0);
    check("rst_zero",  {31'd0, out_zero}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].lat, vecs[i].lz,
               vecs[i].res, vecs[i].zero, 0);
    end

    // Stall in DONE for 5 cycles.
    run_word("stall", 32'hF000_0000, 3, 6'd0, 32'hF000_0000, 1'b0, 5);

    // Reset pulse during SCAN of 0x000000FF.
    @(negedge clk);
    in_data  = 32'h0000_00FF;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_data",  out_data, 32'd0);
    check("midrst_lz",    {26'd0, out_lz}, 32'd0);
    check("midrst_zero",  {31'd0, out_zero}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", {31'd0, in_ready}, 32'd1);
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      check("midrst_no_result", seen, 0);
    end
    run_word("post_rst", 32'h0000_00FF, 6, 6'd24, 32'hFF00_0000, 1'b0, 0);

    // Back-to-back words with out_ready held high.
    @(negedge clk);
    in_data   = 32'h8000_0000;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sent      = 0;
    n_res     = 0;
    first_cyc = 0;
    gap       = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) begin
        if (n_res == 0) first_cyc = c;
        else if (n_res == 1) gap = c - first_cyc;
        if (n_res < 2) lz_seen[n_res] = out_lz;
        n_res++;
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        sent++;
        if (sent == 1) in_data = 32'h4000_0000;
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("b2b_count", n_res, 2);
`ifdef LZD_NORM_FAST_TURN_EN
    check("b2b_gap", gap, 3);
`else
    check("b2b_gap", gap, 4);
`endif
    if (n_res >= 2) begin
      check("b2b_lz0", {26'd0, lz_seen[0]}, 32'd0);
      check("b2b_lz1", {26'd0, lz_seen[1]}, 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
